button_write_strobe: RTL and testbench
======================================

Name: button_write_strobe

Overview:
- Upstream stage for the four-slot switch-value store (demux → four D latches → mux to LEDs).
- Turns the raw centre pushbutton into a clean, single-cycle write strobe.
- Captures the 8-bit data switches and 2-bit slot-select switches at the instant of the press, giving the store a coherent write command (enable, slot, data).
- Synchronises all asynchronous board inputs and rejects mechanical bounce on both press and release.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles the button must be stable before a press or release is accepted (10 ms at 100 MHz); legal range ≥ 2
- DATA_W, 8, width of data switches and wr_data
- SEL_W, 2, width of slot select and wr_sel
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock, 100 MHz board oscillator
- reset  in  1  synchronous, active-high reset
- btn_raw  in  1  raw pushbutton, asynchronous, bouncy
- data_in  in  DATA_W  raw data switches, asynchronous
- sel_in  in  SEL_W  raw slot-select switches, asynchronous
- wr_en  out  1  one-cycle write strobe per accepted press
- wr_sel  out  SEL_W  slot captured with the press
- wr_data  out  DATA_W  data captured with the press
- btn_level  out  1  debounced button level; 1 in HELD and RELEASE_WAIT
- press_count  out  8  count of accepted presses, wraps

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Synchronisers:
  - btn_raw, data_in and sel_in each pass through a 2-FF synchroniser.
  - All internal logic uses only the synchronised copies: btn_s, data_s, sel_s.
- Reset values, applied while reset is sampled high:
  - state = IDLE, cnt = 0.
  - wr_en, wr_sel, wr_data, btn_level, press_count all 0.
  - Synchroniser flops 0.
- Reset overrides everything. Reset mid-debounce or mid-hold returns to IDLE with no pulse.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. cnt is the debounce counter.
- IDLE:
  - btn_s = 1 → PRESS_WAIT, cnt ← 0.
  - Otherwise stay in IDLE.
- PRESS_WAIT:
  - btn_s = 0 → IDLE. Glitch rejected, no pulse.
  - btn_s = 1 and cnt = DEBOUNCE_CYCLES−1 → HELD. On the same edge: wr_en ← 1, wr_sel ← sel_s, wr_data ← data_s, press_count ← press_count+1.
  - Otherwise cnt ← cnt+1.
- HELD:
  - btn_s = 0 → RELEASE_WAIT, cnt ← 0.
  - Otherwise stay in HELD; a held button never re-fires.
- RELEASE_WAIT:
  - btn_s = 1 → HELD. Release bounce; no new pulse.
  - cnt = DEBOUNCE_CYCLES−1 → IDLE.
  - Otherwise cnt ← cnt+1.
- wr_en:
  - High for exactly one cycle (the first cycle in HELD).
  - Cleared on every other edge.
- Latency:
  - Button clean-high from edge e0, the first edge sampling btn_raw = 1.
  - wr_en is high in the cycle following edge e(DEBOUNCE_CYCLES+2).
  - For DEBOUNCE_CYCLES = 4, wr_en rises after e6 and falls after e7.
- Capture:
  - wr_sel and wr_data change only on the strobe edge and hold until the next accepted press.
  - Switch changes at any other time have no effect.
- Wrap-around: press_count 255 → 0 on the next accepted press. It is not saturating.
- Minimum press spacing: one press → release cycle takes at least 2·DEBOUNCE_CYCLES+2 cycles. Faster toggling yields no extra strobes.

Decomposition:
- Shared package button_pkg:
  - btn_state_t enum: IDLE = 2'd0, PRESS_WAIT = 2'd1, HELD = 2'd2, RELEASE_WAIT = 2'd3.
  - Constant DEBOUNCE_CYCLES_DEFAULT = 1_000_000.
  - Constant BOARD_CLK_HZ = 100_000_000.
- One sub-module: sync_2ff, parameter WIDTH, ports clk, reset, d, q.
  - Instantiated once for btn_raw (WIDTH 1).
  - Instantiated once for the concatenated {sel_in, data_in} (WIDTH SEL_W+DATA_W).

Test Plan (DEBOUNCE_CYCLES = 4 unless noted):
- Clean press, data_in = 8'hA5, sel_in = 2'b10, btn_raw held high 20 cycles from e0 → wr_en high only in the cycle after e6; wr_data = 8'hA5; wr_sel = 2'b10; press_count = 1; btn_level = 1 from that cycle.
- Glitch: btn_raw high for 3 cycles, then low 10 → FSM enters PRESS_WAIT and returns to IDLE; no wr_en; press_count = 0; btn_level = 0 throughout.
- Hold 200 cycles with data_in toggling 8'h00/8'hFF every cycle after the strobe → exactly one wr_en; wr_data frozen at the value captured on the strobe edge.
- Release bounce: after an accepted press, btn_raw low 2 cycles, high 1, low 10 → btn_level stays 1 through the bounce and falls once after debounce; no second wr_en; press_count = 1.
- Reset mid-operation: reset asserted one cycle during PRESS_WAIT (cnt = 2), button kept high → all outputs 0; fresh debounce restarts from IDLE; wr_en occurs 4+3 edges after reset deasserts while btn_s stays 1.
- Wrap: 256 clean press/release cycles with data_in = press index → press_count returns to 0; wr_data = 8'hFF after press 256; 256 strobes counted.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the pushbutton write-strobe front end.
package button_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms at the board clock rate.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned BOARD_CLK_HZ            = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the raw input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_write_strobe.sv
// Debounces the centre pushbutton and issues a one-cycle write command
// (strobe, slot, data) captured at the moment a press is accepted.
module button_write_strobe
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned SEL_W           = 2,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  sel_in,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              btn_level,
    output logic [7:0]        press_count
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_s;
    logic [DATA_W-1:0] data_s;
    logic [SEL_W-1:0]  sel_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // Switches share one synchroniser so slot and data stay paired.
    sync_2ff #(
        .WIDTH (SEL_W + DATA_W)
    ) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     ({sel_in, data_in}),
        .q     ({sel_s, data_s})
    );

    btn_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              btn_level_q, btn_level_d;
    logic [7:0]        press_count_q, press_count_d;

    // Debounce FSM next state, strobe generation and press capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_en_d       = 1'b0;
        wr_sel_d      = wr_sel_q;
        wr_data_d     = wr_data_q;
        press_count_d = press_count_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CntLast) begin
                    state_d       = HELD;
                    wr_en_d       = 1'b1;
                    wr_sel_d      = sel_s;
                    wr_data_d     = data_s;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to HELD without a new strobe.
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CntLast) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        btn_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_sel_q      <= '0;
            wr_data_q     <= '0;
            btn_level_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_sel_q      <= wr_sel_d;
            wr_data_q     <= wr_data_d;
            btn_level_q   <= btn_level_d;
            press_count_q <= press_count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_sel      = wr_sel_q;
    assign wr_data     = wr_data_q;
    assign btn_level   = btn_level_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_button_write_strobe.sv
// Directed bench for button_write_strobe with DEBOUNCE_CYCLES = 4.
module tb_button_write_strobe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] sel_in = 2'b00;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       btn_level;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_write_strobe #(
        .DEBOUNCE_CYCLES (4),
        .DATA_W          (8),
        .SEL_W           (2),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .data_in     (data_in),
        .sel_in      (sel_in),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    // One clock edge, then settle so outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = 1'b0; data_in = 8'h00; sel_in = 2'b00;
        tick(); tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_sel !== 2'b00) begin n_fail++; $display("FAIL reset_wr_sel: got %b expected 00", wr_sel); end
        n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_btn_level: got %b expected 0", btn_level); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_press_count: got %0d expected 0", press_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            btn_raw = (i < 3);
            tick();
            n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL glitch_wr_en c%0d: got %b expected 0", i, wr_en); end
            n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL glitch_btn_level c%0d: got %b expected 0", i, btn_level); end
        end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL glitch_press_count: got %0d expected 0", press_count); end
    endtask

    task automatic test_clean_press();
        logic exp;
        data_in = 8'hA5; sel_in = 2'b10; btn_raw = 1'b1;
        // Loop index i is the edge number e_i counted from the first high sample.
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = (i == 6);
            n_checks++; if (wr_en !== exp) begin n_fail++; $display("FAIL clean_wr_en e%0d: got %b expected %b", i, wr_en, exp); end
            exp = (i >= 6);
            n_checks++; if (btn_level !== exp) begin n_fail++; $display("FAIL clean_btn_level e%0d: got %b expected %b", i, btn_level, exp); end
        end
        n_checks++; if (wr_data !== 8'hA5) begin n_fail++; $display("FAIL clean_wr_data: got %h expected a5", wr_data); end
        n_checks++; if (wr_sel !== 2'b10) begin n_fail++; $display("FAIL clean_wr_sel: got %b expected 10", wr_sel); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL clean_press_count: got %0d expected 1", press_count); end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i < 6);
            n_checks++; if (btn_level !== exp) begin n_fail++; $display("FAIL clean_release_level r%0d: got %b expected %b", i, btn_level, exp); end
            n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL clean_release_wr_en r%0d: got %b expected 0", i, wr_en); end
        end
    endtask

    task automatic test_hold();
        int n_strobe;
        n_strobe = 0;
        data_in = 8'h3C; sel_in = 2'b01; btn_raw = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i >= 7) data_in = (i % 2 == 1) ? 8'hFF : 8'h00;
            tick();
            if (wr_en === 1'b1) n_strobe++;
            if (i >= 6) begin
                n_checks++; if (wr_data !== 8'h3C) begin n_fail++; $display("FAIL hold_wr_data e%0d: got %h expected 3c", i, wr_data); end
            end
        end
        n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL hold_strobes: got %0d expected 1", n_strobe); end
        n_checks++; if (wr_sel !== 2'b01) begin n_fail++; $display("FAIL hold_wr_sel: got %b expected 01", wr_sel); end
        n_checks++; if (press_count !== 8'd2) begin n_fail++; $display("FAIL hold_press_count: got %0d expected 2", press_count); end
        btn_raw = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL hold_release_level: got %b expected 0", btn_level); end
    endtask

    task automatic test_release_bounce();
        logic [12:0] pat;
        logic        exp;
        pat = 13'b0000000000100;
        data_in = 8'h5A; sel_in = 2'b11; btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (wr_data !== 8'h5A) begin n_fail++; $display("FAIL bounce_wr_data: got %h expected 5a", wr_data); end
        n_checks++; if (press_count !== 8'd3) begin n_fail++; $display("FAIL bounce_press_count_pre: got %0d expected 3", press_count); end
        // Low 2, high 1, low 10: level must hold until edge r9.
        for (int i = 0; i < 13; i++) begin
            btn_raw = pat[i];
            tick();
            exp = (i < 9);
            n_checks++; if (btn_level !== exp) begin n_fail++; $display("FAIL bounce_btn_level r%0d: got %b expected %b", i, btn_level, exp); end
            n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL bounce_wr_en r%0d: got %b expected 0", i, wr_en); end
        end
        n_checks++; if (press_count !== 8'd3) begin n_fail++; $display("FAIL bounce_press_count: got %0d expected 3", press_count); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid();
        logic exp;
        data_in = 8'h77; sel_in = 2'b10; btn_raw = 1'b1;
        // After e4 the FSM sits in PRESS_WAIT with cnt = 2.
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_sel !== 2'b00) begin n_fail++; $display("FAIL rmid_wr_sel: got %b expected 00", wr_sel); end
        n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rmid_wr_data: got %h expected 00", wr_data); end
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL rmid_btn_level: got %b expected 0", btn_level); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL rmid_press_count: got %0d expected 0", press_count); end
        reset = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = (j == 7);
            n_checks++; if (wr_en !== exp) begin n_fail++; $display("FAIL rmid_restart_wr_en er+%0d: got %b expected %b", j, wr_en, exp); end
            exp = (j >= 7);
            n_checks++; if (btn_level !== exp) begin n_fail++; $display("FAIL rmid_restart_level er+%0d: got %b expected %b", j, btn_level, exp); end
        end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL rmid_restart_count: got %0d expected 1", press_count); end
        n_checks++; if (wr_data !== 8'h77) begin n_fail++; $display("FAIL rmid_restart_wr_data: got %h expected 77", wr_data); end
        n_checks++; if (wr_sel !== 2'b10) begin n_fail++; $display("FAIL rmid_restart_wr_sel: got %b expected 10", wr_sel); end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_wrap();
        int         n_strobe;
        logic [7:0] exp_cnt;
        logic [7:0] exp_data;
        n_strobe = 0;
        reset = 1'b1; sel_in = 2'b00;
        tick();
        reset = 1'b0;
        tick();
        for (int p = 0; p < 256; p++) begin
            exp_data = 8'(p);
            exp_cnt  = 8'(p + 1);
            data_in  = exp_data;
            btn_raw  = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (wr_en === 1'b1) n_strobe++;
            end
            n_checks++; if (press_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_count p%0d: got %0d expected %0d", p, press_count, exp_cnt); end
            n_checks++; if (wr_data !== exp_data) begin n_fail++; $display("FAIL wrap_wr_data p%0d: got %h expected %h", p, wr_data, exp_data); end
            btn_raw = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (wr_en === 1'b1) n_strobe++;
            end
        end
        n_checks++; if (n_strobe !== 256) begin n_fail++; $display("FAIL wrap_strobes: got %0d expected 256", n_strobe); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL wrap_final_count: got %0d expected 0", press_count); end
        n_checks++; if (wr_data !== 8'hFF) begin n_fail++; $display("FAIL wrap_final_data: got %h expected ff", wr_data); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_hold();
        test_release_bounce();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
